// File: rtl/digit_serial_cla_adder.sv
// Digit-serial adder: DIGIT bits per clock through one carry-lookahead slice, valid/ready on both sides.
// Define DIGIT_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_out.
module digit_serial_cla_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out,
    output logic             busy
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic [DIGIT-1:0] aDig, bDig, gen, prop, digSum;
    logic [DIGIT:0]   cy;
    logic             pChain;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Each carry is the OR of generate terms gated by the propagate chain, not a ripple of prior carries.
    always_comb begin
        aDig   = a_q[int'(cnt_q)*DIGIT +: DIGIT];
        bDig   = b_q[int'(cnt_q)*DIGIT +: DIGIT];
        gen    = aDig & bDig;
        prop   = aDig ^ bDig;
        cy     = '0;
        cy[0]  = carry_q;
        pChain = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            cy[i+1] = gen[i];
            pChain  = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                cy[i+1] = cy[i+1] | (pChain & gen[j]);
                pChain  = pChain & prop[j];
            end
            cy[i+1] = cy[i+1] | (pChain & carry_q);
        end
        digSum = prop ^ cy[DIGIT-1:0];
    end

    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (accept) state_d = ADD;
            ADD: begin
                sum_d[int'(cnt_q)*DIGIT +: DIGIT] = digSum;
                carry_d = cy[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = cy[DIGIT];
                    cnt_d   = '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    ovf_d   = cy[DIGIT] ^ cy[DIGIT-1];
`endif
                end
            end
            DONE: if (out_ready) state_d = accept ? ADD : IDLE;
            default: state_d = IDLE;
        endcase
        // A DONE-state accept overrides the counter/carry so the next add starts on the same edge.
        if (accept) begin
            a_d     = a_in;
            b_d     = b_in;
            carry_d = c_in;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD);
    assign s_out     = sum_q;
    assign c_out     = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    assign ovf_out   = ovf_q;
`endif

endmodule
